// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing datapath.
//   sc_dec_state_t     : decoder FSM states (IDLE, COUNT, DONE)
//   SC_STREAM_LEN_LOG2 : default log2 stream length. The encoders reuse it so
//                        that the stream lengths on both ends agree.
// ---------------------------------------------------------------------------
package sc_pkg;

  localparam int SC_STREAM_LEN_LOG2 = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sc_dec_state_t;

endpackage : sc_pkg

// File: rtl/sc_ones_counter.sv
// ---------------------------------------------------------------------------
// sc_ones_counter
// Counts the ones in a bit sequence. The count is N+1 bits wide, so a window
// of 2^N ones (the all-ones case) still fits without overflow.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-high; clears the count
//   clear   : synchronous clear at the start of a new window
//   enable  : bit_in is accepted this cycle
//   bit_in  : stream bit; adds 1 to the count when enable is high
//   count   : [N:0] running number of ones
// ---------------------------------------------------------------------------
module sc_ones_counter #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [N:0] count
);

  // NOTE: sequential state is written with non-blocking (<=) assignments only,
  // so every flop samples the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + (N+1)'(bit_in);
    end
  end

endmodule : sc_ones_counter

// File: rtl/sc_stream_decoder.sv
// ---------------------------------------------------------------------------
// sc_stream_decoder
// Converts a unipolar stochastic bitstream back to binary. It counts the ones
// over a window of 2^STREAM_LEN_LOG2 accepted bits, using a start/busy/done
// handshake so that one conversion runs at a time.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high; aborts any conversion in flight
//   start     : launch a conversion (only honoured in IDLE or DONE)
//   bit_in    : stochastic stream bit
//   bit_valid : bit_in is valid this cycle (only honoured in COUNT)
//   busy      : high while a window is being counted
//   done      : one-cycle pulse when the result is ready
//   value     : [STREAM_LEN_LOG2:0] ones in the last completed window
// All outputs are registered.
// ---------------------------------------------------------------------------
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int STREAM_LEN_LOG2 = SC_STREAM_LEN_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     busy,
  output logic                     done,
  output logic [STREAM_LEN_LOG2:0] value
);

  localparam int N = STREAM_LEN_LOG2;

  sc_dec_state_t state, state_next;

  logic [N-1:0] bit_cnt;
  logic [N:0]   ones_cnt;
  logic         clear_cnt;
  logic         accept;
  logic         last_bit;

  // The bit counter wraps to zero on the last bit, so "last" is simply all ones.
  assign last_bit = (bit_cnt == '1);

  // NOTE: every combinational output gets a default before the case statement.
  // Without the defaults, a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_next = state;
    clear_cnt  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear_cnt  = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (bit_valid) begin
          accept = 1'b1;
          if (last_bit) state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          clear_cnt  = 1'b1;
          state_next = COUNT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_cnt) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + N'(1);
    end
  end

  // busy and done are registered from the next state. They therefore line up
  // with the state register and never see a combinational path from an input.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      value <= '0;
    end else begin
      busy <= (state_next == COUNT);
      done <= (state_next == DONE);
      // The ones counter has not yet absorbed the final bit at this edge,
      // so that bit is added here.
      if (accept && last_bit) begin
        value <= ones_cnt + (N+1)'(bit_in);
      end
    end
  end

  sc_ones_counter #(
    .N (N)
  ) u_ones_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_cnt),
    .enable (accept),
    .bit_in (bit_in),
    .count  (ones_cnt)
  );

endmodule : sc_stream_decoder

// File: tb/tb_sc_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_sc_stream_decoder
// Self-checking bench. u_dut uses a 16-bit window. u_dut8 uses a 256-bit window
// and is fed from a software LFSR plus a comparator encoder. Expected counts
// and timing come from the bench's own model of each window.
// ---------------------------------------------------------------------------
module tb_sc_stream_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, bit_in, bit_valid;
  logic       busy, done;
  logic [4:0] value;

  logic       start8, bit_in8, bit_valid8;
  logic       busy8, done8;
  logic [8:0] value8;

  int n_checks = 0;
  int n_errors = 0;
  int exp_value = 0;

  always #5 clk = ~clk;

  sc_stream_decoder #(.STREAM_LEN_LOG2(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .value     (value)
  );

  sc_stream_decoder #(.STREAM_LEN_LOG2(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start8),
    .bit_in    (bit_in8),
    .bit_valid (bit_valid8),
    .busy      (busy8),
    .done      (done8),
    .value     (value8)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit conversion. The call must begin #1 after an edge, in IDLE or
  // DONE. Idle cycles are placed at random positions but never after the
  // final valid bit. On return we are in the cycle where done must be high.
  task automatic conv4(input logic [15:0] bits, input int gaps, input bit mid_start,
                       input string tag);
    int seq[$];
    int bi = 0;
    int busy_cycles = 0;
    bit done_early = 1'b0;
    bit value_held = 1'b1;
    int exp = $countones(bits);
    for (int i = 0; i < 16; i++) seq.push_back(1);
    for (int g = 0; g < gaps; g++) seq.insert($urandom_range(0, seq.size() - 1), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 1);
    for (int c = 0; c < seq.size(); c++) begin
      bit_valid = (seq[c] == 1);
      bit_in    = (seq[c] == 1) ? bits[bi] : 1'($urandom);
      if (seq[c] == 1) bi++;
      start     = mid_start && (c == 3);
      if (busy === 1'b1) busy_cycles++;
      if (done !== 1'b0) done_early = 1'b1;
      if (value !== 5'(exp_value)) value_held = 1'b0;
      step();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    start     = 1'b0;
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy in done"}, 32'(busy), 0);
    check({tag, " value"}, 32'(value), 32'(exp));
    check({tag, " busy cycles"}, 32'(busy_cycles), 32'(16 + gaps));
    check({tag, " no early done"}, 32'(done_early), 0);
    check({tag, " value held"}, 32'(value_held), 1);
    exp_value = exp;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  initial begin
    logic [31:0] lfsr;
    int          ref_ones;
    bit          early8;

    reset = 1'b1;
    start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    start8 = 1'b0; bit_in8 = 1'b0; bit_valid8 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset value", 32'(value), 0);
    step();

    // All ones, then check that the done pulse lasts a single cycle.
    conv4(16'hFFFF, 0, 1'b0, "ones");
    step();
    check("done one cycle", 32'(done), 0);
    check("value held idle", 32'(value), 16);

    conv4(16'h0000, 0, 1'b0, "zeros");
    step();
    conv4(16'h5555, 0, 1'b0, "alt");
    step();

    // 1,1,0,0 repeated, with five idle cycles mixed in.
    conv4(16'h3333, 5, 1'b0, "gapped");
    step();

    // Valid ones presented in IDLE must not leak into the next window.
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) step();
    bit_valid = 1'b0; bit_in = 1'b0;
    check("idle ignore busy", 32'(busy), 0);
    conv4(16'h0000, 0, 1'b0, "idle ignore");
    step();
    conv4(16'hA5C3, 0, 1'b1, "mid start");
    step();

    // Back-to-back conversions: start is raised during the DONE cycle.
    conv4(16'hFFFF, 0, 1'b0, "b2b first");
    conv4(16'h0F0F, 2, 1'b0, "b2b second");
    step();

    // Reset after 7 bits discards the partial window and clears value.
    start = 1'b1; step(); start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (7) step();
    bit_valid = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort value", 32'(value), 0);
    exp_value = 0;
    step();
    conv4(16'hFFFF, 0, 1'b0, "after abort");
    step();

    for (int r = 0; r < 6; r++) begin
      conv4(16'($urandom), $urandom_range(0, 6), 1'(r % 2), $sformatf("rand%0d", r));
      if (r % 3 != 2) step();
    end

    // 256-bit window fed by an LFSR and a comparator encoder (threshold 64/256).
    lfsr = 32'hACE1;
    for (int w = 0; w < 2; w++) begin
      ref_ones = 0;
      early8   = 1'b0;
      start8 = 1'b1; step(); start8 = 1'b0;
      for (int i = 0; i < 256; i++) begin
        lfsr       = lfsr_next(lfsr);
        bit_valid8 = 1'b1;
        bit_in8    = (lfsr[7:0] < 8'd64);
        if (bit_in8) ref_ones++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) early8 = 1'b1;
        step();
      end
      bit_valid8 = 1'b0;
      bit_in8    = 1'b0;
      check($sformatf("rng%0d busy window", w), 32'(early8), 0);
      check($sformatf("rng%0d done", w), 32'(done8), 1);
      check($sformatf("rng%0d value", w), 32'(value8), 32'(ref_ones));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sc_stream_decoder

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Converts a unipolar stochastic bitstream back to a binary value by counting the ones over a fixed window of 2^STREAM_LEN_LOG2 valid bits. It is the decoding end of the stochastic datapath: encoders compare a binary operand against the LFSR words from `rng` to produce streams, and this block turns a result stream back into a count for readout or checking. It uses a start/busy/done handshake so a controller can launch one conversion at a time.

## Interface

Parameters:
- `STREAM_LEN_LOG2`, default 8: window length is 2^STREAM_LEN_LOG2 accepted bits; legal range 1..16.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new conversion; honoured only in IDLE or DONE.
- `bit_in`  in  1: stochastic stream bit.
- `bit_valid`  in  1: `bit_in` is valid this cycle; honoured only in COUNT.
- `busy`  out  1: high while in COUNT.
- `done`  out  1: one-cycle pulse when the conversion completes.
- `value`  out  STREAM_LEN_LOG2+1: number of ones in the last completed window. Range 0..2^STREAM_LEN_LOG2.

## Operation

- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - `start`=1: clear the bit counter and the ones counter, then go to COUNT.
  - `bit_valid` is ignored.
- COUNT:
  - On each cycle with `bit_valid`=1, the ones counter adds `bit_in` and the bit counter increments.
  - If the accepted bit is the last one (bit counter = 2^STREAM_LEN_LOG2−1), load `value` with the final count, including this bit, and go to DONE.
  - `start` is ignored. Cycles with `bit_valid`=0 change nothing.
- DONE:
  - Lasts exactly one cycle, with `done`=1.
  - `start`=1: clear counters and go to COUNT. Back-to-back conversions are allowed.
  - Otherwise go to IDLE.
- Width rules:
  - The bit counter is STREAM_LEN_LOG2 bits and wraps to 0 naturally on the last bit.
  - The ones counter is STREAM_LEN_LOG2+1 bits. It cannot overflow, because an all-ones window gives exactly 2^STREAM_LEN_LOG2.
- `value` holds its last result through IDLE and through the next COUNT. It updates only when a conversion completes.
- Reset, including in the middle of a conversion: state returns to IDLE and both counters clear. The partial window is discarded.

## Timing

- Reset values: `busy`=0, `done`=0, `value`=0, state IDLE.
- `start` sampled high at edge t (state IDLE or DONE): `busy`=1 from cycle t+1. The first bit can be accepted at edge t+1.
- The last bit is accepted at edge k: `done`=1 and `value` valid during cycle k+1, with `busy`=0 in that cycle.
- With `bit_valid` held high, the latency from the `start` edge to `done` is 2^STREAM_LEN_LOG2+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `sc_pkg`:
  - `sc_dec_state_t` enum (IDLE, COUNT, DONE).
  - Constant default `SC_STREAM_LEN_LOG2 = 8`, reused by the encoders so stream lengths agree.
- One natural sub-module, `sc_ones_counter`:
  - Inputs: clear, enable and bit.
  - Output: an N+1-bit count.
  - The FSM and the bit counter stay in the top module.

## Test plan

All scenarios use STREAM_LEN_LOG2=4 (16-bit window) unless stated.

1. **All ones:** `start` pulse, then 16 cycles with `bit_valid`=1, `bit_in`=1 → `done` during cycle 17 after the start edge, `value`=16, `busy` high for exactly 16 cycles.
2. **All zeros:** same stimulus with `bit_in`=0 → `value`=0. Then a second start with alternating 1,0 → `value`=8.
3. **Gapped valid:** 16 valid bits (pattern 1,1,0,0 repeated) interleaved with 5 idle cycles → `value`=8, `done` delayed by exactly 5 cycles relative to scenario 1.
4. **Ignored inputs:**
   - `bit_valid`=1 with `bit_in`=1 for 3 cycles in IDLE, then a normal all-zeros window → `value`=0.
   - `start` pulsed mid-COUNT → no restart, `done` timing unchanged.
5. **Back-to-back and reset:**
   - `start` asserted during the DONE cycle → COUNT entered next cycle with no IDLE gap, and the second result is correct.
   - `reset` asserted after 7 bits of a window → `busy`=0, `done`=0, `value`=0. A subsequent all-ones window gives 16.
6. **Integration with `rng`:**
   - Setup: STREAM_LEN_LOG2=8, seed 32'hACE1, encoder bit = (`rnd1[7:0]` < 8'd64).
   - Required: `value` equals the count computed by the bench's software model of the LFSR and comparator, bit-exact.
